pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter PC_STEP, default 4, sequential increment.
REQ-004 Parameter RAS_DEPTH, default 4 (power of 2, >=2), return-address-stack entries.
REQ-005 CLK  in  1  single clock; all state updates on posedge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  PC update enable; 0 = stall, all state holds.
REQ-008 branch_taken  in  1  load branch_target.
REQ-009 branch_target  in  ADDR_W  branch destination.
REQ-010 jump  in  1  load jump_target.
REQ-011 call  in  1  load jump_target and push return address.
REQ-012 jump_target  in  ADDR_W  jump/call destination.
REQ-013 ret  in  1  pop RAS and load popped address.
REQ-014 ret_target  in  ADDR_W  fallback destination for ret on empty RAS.
REQ-015 halt  in  1  enter HALTED state.
REQ-016 pc  out  ADDR_W  current PC (registered).
REQ-017 npc  out  ADDR_W  pc + PC_STEP (combinational).
REQ-018 halted  out  1  high in HALTED state.
REQ-019 ras_empty / ras_full  out  1 each  RAS occupancy flags.
REQ-020 ras_err  out  1  sticky RAS overflow/underflow flag.

Function
REQ-021 The block SHALL have states RUN and HALTED; RUN -> HALTED when en && halt; HALTED exits only via RST.
REQ-022 In RUN with en=1, the next pc SHALL be selected by priority: halt (hold pc) > ret > call/jump > branch_taken > pc+PC_STEP.
REQ-023 In RUN with en=0, or in HALTED, pc, RAS and ras_err SHALL hold regardless of other inputs.
REQ-024 Arithmetic SHALL be modulo 2^ADDR_W; pc+PC_STEP wraps silently to 0.
REQ-025 call SHALL push npc (pc+PC_STEP) and load jump_target in the same cycle; jump alone pushes nothing.
REQ-026 ret with RAS non-empty SHALL load the top entry and pop it in the same cycle.
REQ-027 ret with RAS empty SHALL load ret_target, leave RAS empty, and set ras_err.
REQ-028 call with RAS full SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH, and set ras_err.
REQ-029 call and ret asserted together SHALL act as ret only; no push.
REQ-030 ras_empty SHALL equal (count==0), ras_full (count==RAS_DEPTH), both registered-state derived, no latency beyond the update edge.
REQ-031 ras_err SHALL remain set until RST.
REQ-032 Next-pc selection SHALL take effect one cycle after the enabling edge, i.e. pc visible on the cycle following the sampled control.

Reset
REQ-033 On RST assertion, asynchronously: pc=RESET_PC, state=RUN, halted=0, RAS count=0, top pointer=0, ras_empty=1, ras_full=0, ras_err=0.
REQ-034 RST mid-operation (including HALTED or with pending call/ret) SHALL discard all RAS contents and state.
REQ-035 RAS storage contents need no reset; only pointer/count are reset.

Structure
REQ-036 cpu_types_pkg SHALL hold word_t, the pc_state_t enum (RUN, HALTED) and pc_sel_t enum (SEL_HOLD, SEL_RET, SEL_JUMP, SEL_BRANCH, SEL_SEQ).
REQ-037 The RAS SHALL be a sub-module pc_ras (push, pop, push_data, top, empty, full, overflow, underflow), parametrised by ADDR_W and RAS_DEPTH.
REQ-038 Next-pc selection SHALL be a single combinational mux driven by a pc_sel_t decode.

Verification (RESET_PC=0, PC_STEP=4, RAS_DEPTH=4, ADDR_W=32)
REQ-039 Release RST, en=1 for 3 cycles then en=0 -> pc 0x0,0x4,0x8,0xC then holds 0xC; npc=0x10.
REQ-040 At pc=0x10 call, jump_target=0x100 -> pc=0x100, ras_empty=0; then ret -> pc=0x14, ras_empty=1, ras_err=0.
REQ-041 Five calls from pc 0x0,0x100,0x200,0x300,0x400 (targets +0x100) -> ras_full after 4th, ras_err=1 after 5th; four rets return 0x404,0x304,0x204,0x104; fifth ret with ret_target=0x800 -> pc=0x800.
REQ-042 branch_taken=1 (0x40) and jump=1 (0x80) same cycle -> pc=0x80; ret+call same cycle with RAS top 0x14 -> pc=0x14, no push.
REQ-043 halt at pc=0x20 -> halted=1, pc stays 0x20 under en/jump; assert RST mid-cycle -> pc=0x0, halted=0, ras_empty=1 immediately.
REQ-044 Force pc=0xFFFF_FFFC via jump, en=1 -> pc=0x0000_0000.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU front-end types: machine word, PC sequencer state
//            and next-pc source selector.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int c_WORD_W = 32;

  typedef logic [c_WORD_W-1:0] word_t;

  // Sequencer run state; HALTED is left only through reset
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  // Source of the next pc, listed from highest to lowest priority
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_RET    = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_SEQ    = 3'd4
  } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Control/status bundle between the fetch controller (master)
//            and the pc sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic              en;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic              call;
  logic [ADDR_W-1:0] jump_target;
  logic              ret;
  logic [ADDR_W-1:0] ret_target;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              halted;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output en, branch_taken, branch_target, jump, call, jump_target,
           ret, ret_target, halt,
    input  pc, npc, halted, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  en, branch_taken, branch_target, jump, call, jump_target,
           ret, ret_target, halt,
    output pc, npc, halted, ras_empty, ras_full, ras_err
  );

endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_ras
// Brief    : Circular return-address stack. A push when full overwrites the
//            oldest entry; a pop when empty changes nothing. Both report
//            through overflow/underflow strobes.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0]  r_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;      // next slot to write; top lives at r_ptr-1
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] w_top_idx;
  logic               w_do_pop;
  logic               w_do_push;

  // Pop wins over push so a simultaneous request never corrupts the stack
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !pop;
  assign w_top_idx = r_ptr - c_PTR_W'(1);

  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_FULL_CNT);
  assign overflow  = w_do_push && full;
  assign underflow = pop && empty;

  // Storage write; contents are don't-care until pushed, so no reset
  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  // Pointer and occupancy; the pointer wraps, the count saturates at depth
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - c_PTR_W'(1);
      r_count <= r_count - c_CNT_W'(1);
    end else if (w_do_push) begin
      r_ptr <= r_ptr + c_PTR_W'(1);
      if (!full) begin
        r_count <= r_count + c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with branch/jump/call/ret selection,
//            return-address stack and a terminal HALTED state.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP   = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  pc_sequencer_if.slave bus
);

  pc_state_t         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;
  logic              r_ras_err;

  pc_sel_t           w_sel;
  logic [ADDR_W-1:0] w_npc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_ret_addr;
  logic              w_active;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_ras_ovf;
  logic              w_ras_unf;

  // Any state change requires RUN and en; halt itself only freezes pc
  assign w_active   = (r_state == RUN) && bus.en;
  assign w_npc      = r_pc + ADDR_W'(PC_STEP);
  assign w_pop      = w_active && !bus.halt && bus.ret;
  assign w_push     = w_active && !bus.halt && !bus.ret && bus.call;
  assign w_ret_addr = w_ras_empty ? bus.ret_target : w_ras_top;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RST       (RST),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_npc),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full),
    .overflow  (w_ras_ovf),
    .underflow (w_ras_unf)
  );

  // Priority decode of the next-pc source
  always_comb begin
    w_sel = SEL_SEQ;
    if (!w_active || bus.halt)         w_sel = SEL_HOLD;
    else if (bus.ret)                  w_sel = SEL_RET;
    else if (bus.call || bus.jump)     w_sel = SEL_JUMP;
    else if (bus.branch_taken)         w_sel = SEL_BRANCH;
  end

  // Single next-pc mux driven by the decoded selector
  always_comb begin
    w_next_pc = r_pc;
    case (w_sel)
      SEL_HOLD:   w_next_pc = r_pc;
      SEL_RET:    w_next_pc = w_ret_addr;
      SEL_JUMP:   w_next_pc = bus.jump_target;
      SEL_BRANCH: w_next_pc = bus.branch_target;
      SEL_SEQ:    w_next_pc = w_npc;
      default:    w_next_pc = r_pc;
    endcase
  end

  // Run/halt state machine with registered pc, halted and sticky RAS error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_halted  <= 1'b0;
      r_ras_err <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.en) begin
            r_pc <= w_next_pc;
            if (w_ras_ovf || w_ras_unf) begin
              r_ras_err <= 1'b1;
            end
            if (bus.halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        HALTED: begin
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.npc       = w_npc;
  assign bus.halted    = r_halted;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_err   = r_ras_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer. Each step queues
//            the expected post-edge status, then pops and compares it after
//            the clock edge that applies the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  import cpu_types_pkg::*;

  typedef struct {
    string tag;
    word_t pc;
    logic  halted;
    logic  empty;
    logic  full;
    logic  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0000_0000),
    .PC_STEP   (4),
    .RAS_DEPTH (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    bus.en            = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.jump_target   = '0;
    bus.ret           = 1'b0;
    bus.ret_target    = '0;
    bus.halt          = 1'b0;
  endtask

  task automatic push_exp(input string tag, input word_t pc, input logic h,
                          input logic e, input logic f, input logic er);
    exp_t x;
    x.tag = tag; x.pc = pc; x.halted = h; x.empty = e; x.full = f; x.err = er;
    sb.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      check("sb_underrun", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check({x.tag, ".pc"},     bus.pc,               x.pc);
      check({x.tag, ".halted"}, {31'd0, bus.halted},  {31'd0, x.halted});
      check({x.tag, ".empty"},  {31'd0, bus.ras_empty}, {31'd0, x.empty});
      check({x.tag, ".full"},   {31'd0, bus.ras_full},  {31'd0, x.full});
      check({x.tag, ".err"},    {31'd0, bus.ras_err},   {31'd0, x.err});
    end
  endtask

  // Queue expectation, apply currently driven controls on one edge, compare
  task automatic step(input string tag, input word_t pc, input logic h,
                      input logic e, input logic f, input logic er);
    push_exp(tag, pc, h, e, f, er);
    @(posedge clk);
    #1;
    compare_out();
    idle();
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    compare_out();
    rst = 1'b0;
    push_exp("released", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    compare_out();

    // Sequential run, then stall under active controls
    step("seq1", 32'h4, 0, 1, 0, 0);
    step("seq2", 32'h8, 0, 1, 0, 0);
    step("seq3", 32'hC, 0, 1, 0, 0);
    bus.en = 1'b0; bus.jump = 1'b1; bus.jump_target = 32'h999;
    step("stall_jump", 32'hC, 0, 1, 0, 0);
    check("npc_stall", bus.npc, 32'h10);
    bus.en = 1'b0; bus.call = 1'b1; bus.ret = 1'b1; bus.ret_target = 32'h777;
    step("stall_callret", 32'hC, 0, 1, 0, 0);
    step("seq4", 32'h10, 0, 1, 0, 0);

    // Single call/ret round trip
    bus.call = 1'b1; bus.jump_target = 32'h100;
    step("call1", 32'h100, 0, 0, 0, 0);
    bus.ret = 1'b1; bus.ret_target = 32'h999;
    step("ret1", 32'h14, 0, 1, 0, 0);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    step("branch", 32'h40, 0, 1, 0, 0);

    // Fill, overflow, drain and underflow the RAS
    bus.jump = 1'b1; bus.jump_target = 32'h0;
    step("jmp0", 32'h0, 0, 1, 0, 0);
    bus.call = 1'b1; bus.jump_target = 32'h100;
    step("c1", 32'h100, 0, 0, 0, 0);
    bus.call = 1'b1; bus.jump_target = 32'h200;
    step("c2", 32'h200, 0, 0, 0, 0);
    bus.call = 1'b1; bus.jump_target = 32'h300;
    step("c3", 32'h300, 0, 0, 0, 0);
    bus.call = 1'b1; bus.jump_target = 32'h400;
    step("c4", 32'h400, 0, 0, 1, 0);
    bus.call = 1'b1; bus.jump_target = 32'h500;
    step("c5_ovf", 32'h500, 0, 0, 1, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h800;
    step("r1", 32'h404, 0, 0, 0, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h800;
    step("r2", 32'h304, 0, 0, 0, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h800;
    step("r3", 32'h204, 0, 0, 0, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h800;
    step("r4", 32'h104, 0, 1, 0, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h800;
    step("r5_unf", 32'h800, 0, 1, 0, 1);

    // Priority: jump over branch; ret over call with no push
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    bus.jump = 1'b1; bus.jump_target = 32'h80;
    step("jump_vs_branch", 32'h80, 0, 1, 0, 1);
    bus.jump = 1'b1; bus.jump_target = 32'h10;
    step("jmp10", 32'h10, 0, 1, 0, 1);
    bus.call = 1'b1; bus.jump_target = 32'h200;
    step("call_top14", 32'h200, 0, 0, 0, 1);
    bus.call = 1'b1; bus.ret = 1'b1; bus.jump_target = 32'h300; bus.ret_target = 32'h999;
    step("ret_and_call", 32'h14, 0, 1, 0, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h60;
    step("ret_nopush", 32'h60, 0, 1, 0, 1);

    // Wrap-around of the sequential increment
    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    step("jmp_top", 32'hFFFF_FFFC, 0, 1, 0, 1);
    check("npc_wrap", bus.npc, 32'h0);
    step("seq_wrap", 32'h0, 0, 1, 0, 1);

    // Halt with a live RAS entry, then reset mid-cycle
    bus.jump = 1'b1; bus.jump_target = 32'h1C;
    step("jmp1c", 32'h1C, 0, 1, 0, 1);
    bus.call = 1'b1; bus.jump_target = 32'h20;
    step("call20", 32'h20, 0, 0, 0, 1);
    bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h500;
    step("halt", 32'h20, 1, 0, 0, 1);
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = 32'h300;
    step("halted_jump", 32'h20, 1, 0, 0, 1);
    bus.ret = 1'b1; bus.ret_target = 32'h444;
    step("halted_ret", 32'h20, 1, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    push_exp("rst_mid", 32'h0, 0, 1, 0, 0);
    compare_out();
    check("npc_rst", bus.npc, 32'h4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    step("post_rst_seq", 32'h4, 0, 1, 0, 0);
    bus.ret = 1'b1; bus.ret_target = 32'h700;
    step("post_rst_ret", 32'h700, 0, 1, 0, 1);

    check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
